fft_ctrl64: RTL and testbench
=============================

// Module: fft_ctrl64
// PURPOSE
//  Sequencer that computes a 64-point FFT as two radix-8 passes over one shared fft_core8 datapath (64 = 8 x 8).
//  Issues one 8-point group per cycle: a banked read address vector, a write address vector and inter-pass twiddle indices.
//  It also drives ping-pong bank selects and start/busy/done handshakes.
//  Sits between the sample buffer (2 banks x 64 words, 8 lanes) and the core8 + twiddle-multiplier pipeline.
// PARAMETERS
//  RD_LAT   2   cycles from rd_en_o to the core result being ready for write; legal 1..15
// PORTS
//  clk         in   1   system clock, rising edge
//  rstn        in   1   reset, asynchronous, active-low
//  start_i     in   1   start request; accepted only in IDLE
//  busy_o      out  1   high whenever state != IDLE
//  done_o      out  1   one-cycle pulse: last pass-1 write issued
//  rd_en_o     out  1   read strobe for one 8-lane group
//  rd_bank_o   out  1   bank read (pass0: 0, pass1: 1)
//  rd_addr_o   out  48  lane k address at [6k+5:6k]
//  wr_en_o     out  1   write strobe, RD_LAT cycles after matching rd_en_o
//  wr_bank_o   out  1   bank written (pass0: 1, pass1: 0)
//  wr_addr_o   out  48  lane k write address at [6k+5:6k]
//  tw_en_o     out  1   apply inter-pass twiddle to this write (pass0 only)
//  tw_idx_o    out  48  lane k W64 exponent at [6k+5:6k], aligned with wr_en_o
// BEHAVIOUR
//  - All outputs are registered. Async reset (rstn=0) forces state IDLE, all counters and pipes 0, and every output 0 immediately.
//  - FSM: IDLE -> (start_i) PASS0 -> GAP -> PASS1 -> DRAIN -> DONE -> IDLE.
//    * PASS0 / PASS1: group counter g runs 0..7, one group per cycle. Exit after g = 7.
//    * GAP: hold until the last pass-0 write has been issued. This is required because every pass-1 group reads from all eight pass-0 groups.
//    * DRAIN: hold until the last pass-1 write has been issued.
//    * DONE: one cycle; done_o = 1, busy_o = 1.
//  - Cycle numbering: edge 0 samples start_i = 1 in IDLE; the first rd_en_o is seen after edge 1.
//    * Pass-0 reads: edges 1..8. Pass-0 writes: 1+L..8+L.
//    * Pass-1 reads: 9+L..16+L. Pass-1 writes: 9+2L..16+2L.
//    * done_o: edge 17+2L; busy_o falls at edge 18+2L. (L = RD_LAT)
//  - Pass 0 (DIT, n = g + 8k):
//    * rd_addr lane k = g + 8k; wr_addr lane k = g + 8k (in place, other bank).
//    * tw_en = 1; tw_idx lane k = (g*k) mod 64.
//  - Pass 1:
//    * rd_addr lane k = 8g + k; wr_addr lane k = g + 8k.
//    * tw_en = 0; tw_idx = 0.
//    * Result is in bank 0 in natural order.
//  - Write side: a RD_LAT-deep shift register of {valid, pass, g}; wr_* are derived from its tail. Write addresses never depend on the read-side counter.
//  - start_i outside IDLE (including the DONE cycle) is ignored and not queued. Accepting start in IDLE at edge N makes busy_o = 1 after edge N.
//  - wr_en_o is never 1 in IDLE. rd_en_o is 1 only in PASS0/PASS1.
//  - All address arithmetic is 6-bit unsigned, modulo 64.
// TESTING
//  1. Hold rstn=0, toggle clk and start_i -> all outputs 0, busy_o 0. Release, no start -> outputs stay 0.
//  2. L=2, pulse start: rd_en at edges 1..8. Group g=2 (edge 3): rd_addr lane3 = 26, rd_bank 0. Writes at edges 3..10, wr_bank 1.
//     Twiddles: group 5 lane 7 tw_idx = 35; group 7 lane 7 tw_idx = 49.
//  3. L=2, same run: pass-1 rd at 11..18. g=1 lane2: rd_addr 10, wr_addr 17 (wr at edge 14).
//     done_o only at edge 21; busy_o 0 from edge 22.
//  4. start_i held high throughout -> second run accepted at edge 22 (not 21). Its rd_en at 23..30. No extra runs during busy.
//  5. rstn pulsed low mid-PASS1 -> outputs 0 asynchronously, no done_o. A new start after release gives a full run with done 21 edges later.
//  6. RD_LAT=1 -> writes 1 cycle after reads, done_o at edge 19. RD_LAT=15 -> done_o at edge 47. No write is lost.

Source files
------------

// File: rtl/fft_ctrl64_if.sv
// rtl/fft_ctrl64_if.sv - handshake and address bus between fft_ctrl64 and buffer/core8 side
interface fft_ctrl64_if;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        rd_en_o;
  logic        rd_bank_o;
  logic [47:0] rd_addr_o;
  logic        wr_en_o;
  logic        wr_bank_o;
  logic [47:0] wr_addr_o;
  logic        tw_en_o;
  logic [47:0] tw_idx_o;

  modport master (
    input  start_i,
    output busy_o, done_o,
    output rd_en_o, rd_bank_o, rd_addr_o,
    output wr_en_o, wr_bank_o, wr_addr_o,
    output tw_en_o, tw_idx_o
  );

  modport slave (
    output start_i,
    input  busy_o, done_o,
    input  rd_en_o, rd_bank_o, rd_addr_o,
    input  wr_en_o, wr_bank_o, wr_addr_o,
    input  tw_en_o, tw_idx_o
  );
endinterface

// File: rtl/fft_ctrl64.sv
// rtl/fft_ctrl64.sv - two-pass radix-8 sequencer for a 64-point FFT over one core8 datapath
module fft_ctrl64 #(
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rstn,
  fft_ctrl64_if.master bus
);

  typedef enum logic [2:0] {IDLE, PASS0, GAP, PASS1, DRAIN, DONE} state_t;

  typedef struct packed {
    logic       v;
    logic       p;
    logic [2:0] g;
  } wr_tag_t;

  state_t     state;
  logic [2:0] grp;
  wr_tag_t    pipe [RD_LAT];
  wr_tag_t    tail;

  assign tail = pipe[RD_LAT-1];

  // Lane k of group g: sample g + 8k, i.e. {k, g} as a 6-bit address.
  function automatic logic [47:0] lanes_strided(input logic [2:0] g);
    logic [47:0] r;
    for (int k = 0; k < 8; k++) r[6*k +: 6] = {3'(k), g};
    return r;
  endfunction

  // Lane k of group g: sample 8g + k, contiguous rows of the pass-0 result.
  function automatic logic [47:0] lanes_contig(input logic [2:0] g);
    logic [47:0] r;
    for (int k = 0; k < 8; k++) r[6*k +: 6] = {g, 3'(k)};
    return r;
  endfunction

  function automatic logic [47:0] lanes_twiddle(input logic [2:0] g);
    logic [47:0] r;
    for (int k = 0; k < 8; k++) r[6*k +: 6] = {3'b000, g} * 6'(k);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      grp           <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      bus.busy_o    <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.rd_en_o   <= 1'b0;
      bus.rd_bank_o <= 1'b0;
      bus.rd_addr_o <= '0;
      bus.wr_en_o   <= 1'b0;
      bus.wr_bank_o <= 1'b0;
      bus.wr_addr_o <= '0;
      bus.tw_en_o   <= 1'b0;
      bus.tw_idx_o  <= '0;
    end else begin
      bus.busy_o    <= 1'b1;
      bus.done_o    <= 1'b0;
      bus.rd_en_o   <= 1'b0;
      bus.rd_bank_o <= 1'b0;
      bus.rd_addr_o <= '0;

      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= '0;

      // Write side is driven only by the delayed tag, never by the read counter.
      bus.wr_en_o   <= tail.v;
      bus.wr_bank_o <= tail.v & ~tail.p;
      bus.wr_addr_o <= tail.v ? lanes_strided(tail.g) : '0;
      bus.tw_en_o   <= tail.v & ~tail.p;
      bus.tw_idx_o  <= (tail.v && !tail.p) ? lanes_twiddle(tail.g) : '0;

      case (state)
        IDLE: begin
          bus.busy_o <= bus.start_i;
          grp        <= '0;
          if (bus.start_i) state <= PASS0;
        end
        PASS0: begin
          bus.rd_en_o   <= 1'b1;
          bus.rd_addr_o <= lanes_strided(grp);
          pipe[0]       <= '{v: 1'b1, p: 1'b0, g: grp};
          grp           <= grp + 3'd1;
          if (grp == 3'd7) state <= GAP;
        end
        GAP: begin
          // Every pass-1 group touches all pass-0 groups, so wait for the last write.
          if (tail.v && !tail.p && tail.g == 3'd7) state <= PASS1;
        end
        PASS1: begin
          bus.rd_en_o   <= 1'b1;
          bus.rd_bank_o <= 1'b1;
          bus.rd_addr_o <= lanes_contig(grp);
          pipe[0]       <= '{v: 1'b1, p: 1'b1, g: grp};
          grp           <= grp + 3'd1;
          if (grp == 3'd7) state <= DRAIN;
        end
        DRAIN: begin
          if (tail.v && tail.p && tail.g == 3'd7) state <= DONE;
        end
        DONE: begin
          bus.done_o <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ctrl64.sv
// tb/tb_fft_ctrl64.sv - self-checking bench for fft_ctrl64 at RD_LAT 2, 1 and 15
module tb_fft_ctrl64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  fft_ctrl64_if bus2 ();
  fft_ctrl64_if bus1 ();
  fft_ctrl64_if bus15 ();

  assign bus2.start_i  = start;
  assign bus1.start_i  = start;
  assign bus15.start_i = start;

  fft_ctrl64 #(.RD_LAT(2))  dut2  (.clk(clk), .rstn(rstn), .bus(bus2));
  fft_ctrl64 #(.RD_LAT(1))  dut1  (.clk(clk), .rstn(rstn), .bus(bus1));
  fft_ctrl64 #(.RD_LAT(15)) dut15 (.clk(clk), .rstn(rstn), .bus(bus15));

  typedef struct {
    int d;
    int kind;
    int lane;
    int exp;
  } vec_t;

  vec_t tbl [8];
  bit   tbl_on = 1'b0;

  int errors = 0;
  int checks = 0;
  int ec = 0;
  int lat [3] = '{2, 1, 15};
  int run_s [3] = '{0, 0, 0};
  bit run_a [3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input int idx, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s L=%0d edge=%0d got=%0h want=%0h", name, lat[idx], ec, act, exp);
    end
  endtask

  task automatic check_dut(input int idx, input logic busy, input logic done,
                           input logic rd_en, input logic rd_bank, input logic [47:0] rd_addr,
                           input logic wr_en, input logic wr_bank, input logic [47:0] wr_addr,
                           input logic tw_en, input logic [47:0] tw_idx);
    int L = lat[idx];
    int d = ec - run_s[idx];
    logic e_busy = 1'b0, e_done = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
    int rg = 0, rp = 0, wg = 0, wp = 0;
    logic [47:0] e_ra = '0, e_wa = '0, e_tw = '0;
    logic [47:0] act;
    if (run_a[idx]) begin
      e_busy = (d <= 17 + 2*L);
      e_done = (d == 17 + 2*L);
      if (d >= 1 && d <= 8) begin e_rd = 1'b1; rp = 0; rg = d - 1; end
      if (d >= 9 + L && d <= 16 + L) begin e_rd = 1'b1; rp = 1; rg = d - 9 - L; end
      if (d >= 1 + L && d <= 8 + L) begin e_wr = 1'b1; wp = 0; wg = d - 1 - L; end
      if (d >= 9 + 2*L && d <= 16 + 2*L) begin e_wr = 1'b1; wp = 1; wg = d - 9 - 2*L; end
    end
    for (int k = 0; k < 8; k++) begin
      e_ra[6*k +: 6] = (rp == 0) ? 6'((rg + 8*k) % 64) : 6'((8*rg + k) % 64);
      e_wa[6*k +: 6] = 6'((wg + 8*k) % 64);
      e_tw[6*k +: 6] = (wp == 0) ? 6'((wg * k) % 64) : 6'd0;
    end
    chk("busy", idx, 48'(busy), 48'(e_busy));
    chk("done", idx, 48'(done), 48'(e_done));
    chk("rd_en", idx, 48'(rd_en), 48'(e_rd));
    chk("wr_en", idx, 48'(wr_en), 48'(e_wr));
    chk("tw_en", idx, 48'(tw_en), 48'(e_wr && wp == 0));
    if (e_rd) begin
      chk("rd_bank", idx, 48'(rd_bank), 48'(rp));
      chk("rd_addr", idx, rd_addr, e_ra);
    end
    if (e_wr) begin
      chk("wr_bank", idx, 48'(wr_bank), 48'(wp == 0));
      chk("wr_addr", idx, wr_addr, e_wa);
      chk("tw_idx", idx, tw_idx, e_tw);
    end
    if (!run_a[idx]) begin
      chk("idle_rd_bank", idx, 48'(rd_bank), 48'd0);
      chk("idle_rd_addr", idx, rd_addr, 48'd0);
      chk("idle_wr_bank", idx, 48'(wr_bank), 48'd0);
      chk("idle_wr_addr", idx, wr_addr, 48'd0);
      chk("idle_tw_idx", idx, tw_idx, 48'd0);
    end
    if (idx == 0 && tbl_on && run_a[idx]) begin
      for (int t = 0; t < 8; t++) begin
        if (tbl[t].d == d) begin
          case (tbl[t].kind)
            0:       act = 48'(rd_addr[6*tbl[t].lane +: 6]);
            1:       act = 48'(wr_addr[6*tbl[t].lane +: 6]);
            2:       act = 48'(tw_idx[6*tbl[t].lane +: 6]);
            3:       act = 48'(done);
            default: act = 48'(busy);
          endcase
          chk($sformatf("vec%0d", t), idx, act, 48'(tbl[t].exp));
        end
      end
    end
  endtask

  task automatic check_all();
    check_dut(0, bus2.busy_o, bus2.done_o, bus2.rd_en_o, bus2.rd_bank_o, bus2.rd_addr_o,
              bus2.wr_en_o, bus2.wr_bank_o, bus2.wr_addr_o, bus2.tw_en_o, bus2.tw_idx_o);
    check_dut(1, bus1.busy_o, bus1.done_o, bus1.rd_en_o, bus1.rd_bank_o, bus1.rd_addr_o,
              bus1.wr_en_o, bus1.wr_bank_o, bus1.wr_addr_o, bus1.tw_en_o, bus1.tw_idx_o);
    check_dut(2, bus15.busy_o, bus15.done_o, bus15.rd_en_o, bus15.rd_bank_o, bus15.rd_addr_o,
              bus15.wr_en_o, bus15.wr_bank_o, bus15.wr_addr_o, bus15.tw_en_o, bus15.tw_idx_o);
  endtask

  task automatic step(input logic st);
    start = st;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rstn) run_a[i] = 1'b0;
      else if (st && (!run_a[i] || ec >= run_s[i] + 18 + 2*lat[i])) begin
        run_a[i] = 1'b1;
        run_s[i] = ec;
      end
    end
    @(negedge clk);
    check_all();
    ec++;
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) run_a[i] = 1'b0;
    check_all();
    step(1'b0);
    rstn = 1'b1;
  endtask

  initial begin
    tbl[0] = '{d: 3,  kind: 0, lane: 3, exp: 26};
    tbl[1] = '{d: 8,  kind: 2, lane: 7, exp: 35};
    tbl[2] = '{d: 10, kind: 2, lane: 7, exp: 49};
    tbl[3] = '{d: 12, kind: 0, lane: 2, exp: 10};
    tbl[4] = '{d: 14, kind: 1, lane: 2, exp: 17};
    tbl[5] = '{d: 20, kind: 3, lane: 0, exp: 0};
    tbl[6] = '{d: 21, kind: 3, lane: 0, exp: 1};
    tbl[7] = '{d: 22, kind: 4, lane: 0, exp: 0};

    // Reset held: start toggling must have no effect.
    for (int i = 0; i < 6; i++) step(i[0]);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0);

    // Single run with spot vectors on the RD_LAT=2 instance.
    tbl_on = 1'b1;
    step(1'b1);
    for (int i = 0; i < 50; i++) step(1'b0);
    tbl_on = 1'b0;

    // start held high: back-to-back runs, none accepted while busy.
    for (int i = 0; i < 100; i++) step(1'b1);
    for (int i = 0; i < 50; i++) step(1'b0);

    // Reset during pass 1 of the RD_LAT=2 instance, then a clean run.
    step(1'b1);
    for (int i = 0; i < 13; i++) step(1'b0);
    async_reset();
    step(1'b0);
    step(1'b1);
    for (int i = 0; i < 50; i++) step(1'b0);

    // Random start pulses with rare asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 50; i++) step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
